// File: rtl/branch_target_buffer.sv
// Fully-associative branch target buffer with per-entry saturating
// direction counters, combinational lookup and single-cycle training.
module branch_target_buffer #(
  parameter int ADDR_W  = 16,
  parameter int ENTRIES = 8,
  parameter int CTR_W   = 2
) (
  input  logic                             clk,
  input  logic                             reset_n,
  input  logic [ADDR_W-1:0]                lookup_pc,
  output logic                             pred_hit,
  output logic                             pred_taken,
  output logic [ADDR_W-1:0]                pred_next_pc,
  input  logic                             upd_valid,
  input  logic [ADDR_W-1:0]                upd_pc,
  input  logic [ADDR_W-1:0]                upd_target,
  input  logic                             upd_taken,
  input  logic                             flush,
  output logic [$clog2(ENTRIES+1)-1:0]     occupancy
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int OCC_W = $clog2(ENTRIES+1);
  localparam logic [CTR_W-1:0] CTR_MAX  = '1;
  localparam logic [CTR_W-1:0] CTR_WEAK =
    CTR_W'(1) << (CTR_W-1);

  logic [ENTRIES-1:0] r_valid;
  logic [ADDR_W-1:0]  r_tag    [ENTRIES];
  logic [ADDR_W-1:0]  r_target [ENTRIES];
  logic [CTR_W-1:0]   r_ctr    [ENTRIES];
  logic [IDX_W-1:0]   r_rr;
  logic [OCC_W-1:0]   r_occ;

  logic             w_lk_hit;
  logic [IDX_W-1:0] w_lk_idx;
  logic             w_up_hit;
  logic [IDX_W-1:0] w_up_idx;
  logic             w_free_any;
  logic [IDX_W-1:0] w_free_idx;
  logic [IDX_W-1:0] w_vic_idx;
  logic             w_hit_tk;
  logic             w_hit_nt;
  logic             w_alloc;
  logic [CTR_W-1:0] w_up_ctr;
  logic [IDX_W-1:0] w_rr_next;

  always_comb begin
    w_lk_hit = 1'b0;
    w_lk_idx = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      if (r_valid[i] && r_tag[i] == lookup_pc) begin
        w_lk_hit = 1'b1;
        w_lk_idx = IDX_W'(i);
      end
    end
  end

  always_comb begin
    w_up_hit = 1'b0;
    w_up_idx = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      if (r_valid[i] && r_tag[i] == upd_pc) begin
        w_up_hit = 1'b1;
        w_up_idx = IDX_W'(i);
      end
    end
  end

  // Scan downwards so the lowest invalid index wins.
  always_comb begin
    w_free_any = 1'b0;
    w_free_idx = '0;
    for (int i = ENTRIES-1; i >= 0; i--) begin
      if (!r_valid[i]) begin
        w_free_any = 1'b1;
        w_free_idx = IDX_W'(i);
      end
    end
  end

  assign w_vic_idx = w_free_any ? w_free_idx : r_rr;
  assign w_hit_tk  = upd_valid & w_up_hit & upd_taken;
  assign w_hit_nt  = upd_valid & w_up_hit & ~upd_taken;
  assign w_alloc   = upd_valid & ~w_up_hit & upd_taken;
  assign w_up_ctr  = r_ctr[w_up_idx];
  assign w_rr_next = (r_rr == IDX_W'(ENTRIES-1)) ?
                     '0 : r_rr + IDX_W'(1);

  assign pred_hit   = w_lk_hit;
  assign pred_taken = w_lk_hit & r_ctr[w_lk_idx][CTR_W-1];
  assign pred_next_pc = pred_taken ? r_target[w_lk_idx]
                                   : lookup_pc + ADDR_W'(1);
  assign occupancy  = r_occ;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_valid <= '0;
      r_rr    <= '0;
      r_occ   <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        r_tag[i]    <= '0;
        r_target[i] <= '0;
        r_ctr[i]    <= '0;
      end
    end else if (flush) begin
      r_valid <= '0;
      r_rr    <= '0;
      r_occ   <= '0;
    end else begin
      unique case (1'b1)
        w_hit_tk: begin
          if (w_up_ctr != CTR_MAX)
            r_ctr[w_up_idx] <= w_up_ctr + CTR_W'(1);
          r_target[w_up_idx] <= upd_target;
        end
        w_hit_nt: begin
          if (w_up_ctr != '0)
            r_ctr[w_up_idx] <= w_up_ctr - CTR_W'(1);
        end
        w_alloc: begin
          r_valid[w_vic_idx]  <= 1'b1;
          r_tag[w_vic_idx]    <= upd_pc;
          r_target[w_vic_idx] <= upd_target;
          r_ctr[w_vic_idx]    <= CTR_WEAK;
          if (w_free_any)
            r_occ <= r_occ + OCC_W'(1);
          else
            r_rr <= w_rr_next;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/branch_target_buffer.md
# branch_target_buffer

Parametrised, fully-associative branch target buffer with saturating-counter direction prediction. It succeeds the single-bit history table in the fetch stage of the pipelined RISC core. It predicts the next PC for the current fetch PC in the same cycle. It is trained by the resolving stage (BEQ/JAL/JLR, R7 writes) one update per cycle.

## Interface
- ADDR_W, 16, PC/target width
- ENTRIES, 8, number of entries; power of two, 2..64
- CTR_W, 2, saturating counter width (≥1)
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset
- lookup_pc  in  ADDR_W  current fetch PC
- pred_hit  out  1  lookup_pc matches a valid entry
- pred_taken  out  1  hit and counter MSB = 1
- pred_next_pc  out  ADDR_W  stored target if pred_taken, else lookup_pc+1 (mod 2^ADDR_W)
- upd_valid  in  1  training request this cycle
- upd_pc  in  ADDR_W  PC of resolved control-transfer instruction
- upd_target  in  ADDR_W  resolved target
- upd_taken  in  1  resolved direction
- flush  in  1  synchronous invalidate of all entries
- occupancy  out  $clog2(ENTRIES+1)  count of valid entries

## Operation
- Per entry state: valid, tag[ADDR_W] (full PC, no aliasing), target[ADDR_W], ctr[CTR_W]; global rr_ptr[$clog2(ENTRIES)].
- Lookup is purely combinational over current state. At most one entry can match, because allocation happens only on a miss.
- Update (upd_valid=1), evaluated against the pre-edge state:
  - Hit, taken: ctr saturating +1 (max 2^CTR_W−1); target ← upd_target.
  - Hit, not taken: ctr saturating −1 (min 0); target unchanged.
  - Miss, taken: allocate. Victim is the lowest-index invalid entry; if all entries are valid, the victim is entry rr_ptr and rr_ptr advances by 1, wrapping ENTRIES−1→0. The new entry gets valid=1, tag=upd_pc, target=upd_target, ctr=2^(CTR_W−1) (weakly taken).
  - Miss, not taken: no state change.
- rr_ptr advances only on an eviction of a valid entry. It does not advance on a fill into an invalid slot.
- flush=1 clears all valid bits and sets rr_ptr to 0. Tags, targets and counters are don't-care. Flush has priority over a same-cycle update, and that update is dropped.
- occupancy is a registered count. It increments on a fill into an invalid slot, is unchanged on an eviction, and goes to 0 on flush.

## Timing
- Reset (reset_n=0, asynchronous): all valid=0, ctr=0, tag/target=0, rr_ptr=0, occupancy=0. Hence pred_hit=0, pred_taken=0, pred_next_pc=lookup_pc+1.
- Lookup latency is 0 cycles (combinational from lookup_pc and state).
- Update latency is 1 cycle: an update accepted at edge N is visible to lookups after edge N.
- Same-cycle lookup and update of the same PC: the lookup returns the pre-update prediction.
- No back-pressure: an update is accepted every cycle that upd_valid=1.
- Reset asserted mid-operation: state clears immediately and asynchronously. Deassertion is synchronised externally.
- lookup_pc=2^ADDR_W−1 with no taken hit: pred_next_pc=0 (wrap).

## Test plan
- **Reset / empty.** Reset, then lookup_pc=0x0010 → pred_hit=0, pred_taken=0, pred_next_pc=0x0011, occupancy=0.
- **Allocate and train.**
  - Update pc=0x0010, target=0x0040, taken=1. Next cycle lookup 0x0010 → hit=1, taken=1, next_pc=0x0040, occupancy=1.
  - Then two not-taken updates: ctr 2→1→0, lookup gives taken=0, next_pc=0x0011.
  - Then three taken updates: ctr saturates at 3.
  - Not-taken update on a miss pc=0x0020: occupancy is unchanged.
- **Replacement (ENTRIES=8).**
  - Taken updates for PCs 0x0100..0x0107 fill entries 0..7, occupancy=8, rr_ptr=0.
  - Taken update at 0x0200 evicts 0x0100 (entry 0). Lookup 0x0100 misses, lookup 0x0200 hits, rr_ptr=1.
  - 8 further new PCs: rr_ptr wraps back to 1.
- **Same-cycle hazard.** Entry 0x0010 has ctr=1. A lookup and a taken update of 0x0010 in the same cycle → that cycle taken=0; next cycle taken=1 (ctr=2).
- **Flush priority.** With occupancy=5, assert flush together with a taken miss update at 0x0300. Next cycle → occupancy=0, lookup 0x0300 misses, rr_ptr=0.
- **Parameter sweep.**
  - ENTRIES=2, CTR_W=1: allocation sets ctr=1; one not-taken update clears the prediction.
  - ENTRIES=64, CTR_W=3: 65 distinct taken PCs → occupancy=64, first PC evicted.
  - Lookup 0xFFFF with no entry → next_pc=0x0000.
